// File: rtl/alu_seq_exec.sv
// Sequential ALU: decodes aluOp/func into a 3-bit control code and executes it behind
// valid/ready handshakes. Single-cycle ops finish in one cycle; MUL/DIVU iterate WIDTH cycles.
//
// state | meaning
// IDLE  | waiting for a request, in_ready = 1
// BUSY  | iterating MUL (shift-add) or DIVU (restoring)
// DONE  | result and flags presented, waiting for out_ready
module alu_seq_exec #(
  parameter int WIDTH     = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       aluOp,
  input  logic [3:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       aluCtr,
  output logic             zero,
  output logic             ovf,
  output logic             dz,
  output logic             illg,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_result;
  logic [WIDTH:0]   r_rem;
  logic [CW-1:0]    r_ctr;
  logic [2:0]       r_alu_ctr;
  logic             r_zero, r_ovf, r_dz, r_illg;

  logic [2:0]       w_dec;
  logic             w_accept, w_md, w_div0, w_go_busy, w_last;
  logic [WIDTH-1:0] w_sum, w_dif, w_res1;
  logic             w_ovf1, w_dz1, w_ill1;
  logic [WIDTH-1:0] w_acc_add, w_quo_nxt, w_iter_res;
  logic [WIDTH+1:0] w_rem_sh;
  logic [WIDTH:0]   w_rem_nxt;
  logic             w_ge;
  logic             w_unused_func;

  // func[0] does not take part in the R-type decode
  assign w_unused_func = func[0];

  always_comb begin
    w_dec = 3'd4;
    if (aluOp == 3'b000)           w_dec = 3'd0;
    else if (aluOp[2])             w_dec = func[3:1];
    else if (aluOp[0] && !aluOp[1]) w_dec = 3'd5;
  end

  assign w_accept  = in_valid && (r_state == S_IDLE);
  assign w_md      = (w_dec[2:1] == 2'b11);
  assign w_div0    = (w_dec == 3'd7) && (b == '0);
  assign w_go_busy = MULDIV_EN && w_md && !w_div0;

  assign w_sum = a + b;
  assign w_dif = a - b;

  always_comb begin
    w_res1 = '0;
    w_ovf1 = 1'b0;
    w_dz1  = 1'b0;
    w_ill1 = 1'b0;
    case (w_dec)
      3'd0: begin
        w_res1 = w_sum;
        w_ovf1 = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      3'd1: begin
        w_res1 = w_dif;
        w_ovf1 = (a[WIDTH-1] != b[WIDTH-1]) && (w_dif[WIDTH-1] != a[WIDTH-1]);
      end
      3'd2: w_res1 = a & b;
      3'd3: w_res1 = a | b;
      3'd4: w_res1 = a ^ b;
      3'd5: w_res1 = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: begin
        if (!MULDIV_EN) begin
          w_ill1 = 1'b1;
        end else if (w_div0) begin
          w_res1 = '1;
          w_dz1  = 1'b1;
        end
      end
    endcase
  end

  // One iteration step; on the last step the result is taken straight from these nets
  assign w_acc_add  = r_acc + (r_b[0] ? r_a : '0);
  assign w_rem_sh   = {r_rem, r_a[WIDTH-1]};
  assign w_ge       = (w_rem_sh >= {2'b00, r_b});
  assign w_rem_nxt  = w_ge ? (w_rem_sh[WIDTH:0] - {1'b0, r_b}) : w_rem_sh[WIDTH:0];
  assign w_quo_nxt  = {r_acc[WIDTH-2:0], w_ge};
  assign w_iter_res = (r_alu_ctr == 3'd6) ? w_acc_add : w_quo_nxt;
  assign w_last     = (r_ctr == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_go_busy ? S_BUSY : S_DONE;
      S_BUSY:  if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_rem     <= '0;
      r_ctr     <= '0;
      r_alu_ctr <= '0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_ovf     <= 1'b0;
      r_dz      <= 1'b0;
      r_illg    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_alu_ctr <= w_dec;
            r_a       <= a;
            r_b       <= b;
            r_acc     <= '0;
            r_rem     <= '0;
            r_ctr     <= CW'(WIDTH);
            r_result  <= w_res1;
            r_zero    <= (w_res1 == '0);
            r_ovf     <= w_ovf1;
            r_dz      <= w_dz1;
            r_illg    <= w_ill1;
          end
        end
        S_BUSY: begin
          r_ctr <= r_ctr - CW'(1);
          r_a   <= r_a << 1;
          if (r_alu_ctr == 3'd6) begin
            r_acc <= w_acc_add;
            r_b   <= r_b >> 1;
          end else begin
            r_acc <= w_quo_nxt;
            r_rem <= w_rem_nxt;
          end
          if (w_last) begin
            r_result <= w_iter_res;
            r_zero   <= (w_iter_res == '0);
            r_ovf    <= 1'b0;
            r_dz     <= 1'b0;
            r_illg   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign result    = r_result;
  assign aluCtr    = r_alu_ctr;
  assign zero      = r_zero;
  assign ovf       = r_ovf;
  assign dz        = r_dz;
  assign illg      = r_illg;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Bench for alu_seq_exec: three instances (8-bit, 8-bit without MUL/DIVU, 32-bit) driven
// by directed operations, with expected results queued at issue and checked at output.
module tb_alu_seq_exec;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req;
  int          sel;
  logic [2:0]  aluOp;
  logic [3:0]  func;
  logic [31:0] a_drv, b_drv;
  logic        out_ready;

  logic        iv0, iv1, iv2;
  assign iv0 = req && (sel == 0);
  assign iv1 = req && (sel == 1);
  assign iv2 = req && (sel == 2);

  logic        rdy0, rdy1, rdy2, ov0, ov1, ov2;
  logic [7:0]  res0, res1;
  logic [31:0] res2;
  logic [2:0]  ctr0, ctr1, ctr2;
  logic        z0, z1, z2, o0, o1, o2, d0, d1, d2, i0, i1, i2, b0, b1, b2;

  alu_seq_exec #(.WIDTH(8), .MULDIV_EN(1'b1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(rdy0), .aluOp(aluOp), .func(func),
    .a(a_drv[7:0]), .b(b_drv[7:0]), .out_valid(ov0), .out_ready(out_ready), .result(res0),
    .aluCtr(ctr0), .zero(z0), .ovf(o0), .dz(d0), .illg(i0), .busy(b0));

  alu_seq_exec #(.WIDTH(8), .MULDIV_EN(1'b0)) u_dut8n (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(rdy1), .aluOp(aluOp), .func(func),
    .a(a_drv[7:0]), .b(b_drv[7:0]), .out_valid(ov1), .out_ready(out_ready), .result(res1),
    .aluCtr(ctr1), .zero(z1), .ovf(o1), .dz(d1), .illg(i1), .busy(b1));

  alu_seq_exec #(.WIDTH(32), .MULDIV_EN(1'b1)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(rdy2), .aluOp(aluOp), .func(func),
    .a(a_drv), .b(b_drv), .out_valid(ov2), .out_ready(out_ready), .result(res2),
    .aluCtr(ctr2), .zero(z2), .ovf(o2), .dz(d2), .illg(i2), .busy(b2));

  logic        obs_ready, obs_valid, obs_z, obs_o, obs_d, obs_i, obs_busy;
  logic [31:0] obs_res;
  logic [2:0]  obs_ctr;

  always_comb begin
    obs_ready = rdy2; obs_valid = ov2; obs_res = res2; obs_ctr = ctr2;
    obs_z = z2; obs_o = o2; obs_d = d2; obs_i = i2; obs_busy = b2;
    case (sel)
      0: begin
        obs_ready = rdy0; obs_valid = ov0; obs_res = {24'h0, res0}; obs_ctr = ctr0;
        obs_z = z0; obs_o = o0; obs_d = d0; obs_i = i0; obs_busy = b0;
      end
      1: begin
        obs_ready = rdy1; obs_valid = ov1; obs_res = {24'h0, res1}; obs_ctr = ctr1;
        obs_z = z1; obs_o = o1; obs_d = d1; obs_i = i1; obs_busy = b1;
      end
      default: ;
    endcase
  end

  int n_tot = 0;
  int n_pass = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  ctr;
    logic        z, o, d, i;
    int          lat;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tot++;
    assert (got === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic op(input int s, input logic [2:0] op_c, input logic [3:0] fn,
                    input logic [31:0] aa, input logic [31:0] bb,
                    input logic [31:0] eres, input logic [2:0] ectr,
                    input logic ez, input logic eo, input logic ed, input logic ei,
                    input int elat, input int hold, input string tag);
    exp_t e;
    int   n;
    int   lat;
    e = '{eres, ectr, ez, eo, ed, ei, elat};
    sb.push_back(e);
    sel = s; aluOp = op_c; func = fn; a_drv = aa; b_drv = bb; req = 1'b1;
    n = 0;
    while (obs_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "/accept"}, 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    req = 1'b0; aluOp = 3'b001; func = 4'b1111; a_drv = 32'hDEADBEEF; b_drv = 32'h0;
    chk({tag, "/busy"}, 32'(obs_busy), 32'd1);
    lat = 1;
    while (obs_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    e = sb.pop_front();
    chk({tag, "/latency"}, lat, e.lat);
    chk({tag, "/result"}, obs_res, e.res);
    chk({tag, "/aluCtr"}, 32'(obs_ctr), 32'(e.ctr));
    chk({tag, "/zero"}, 32'(obs_z), 32'(e.z));
    chk({tag, "/ovf"}, 32'(obs_o), 32'(e.o));
    chk({tag, "/dz"}, 32'(obs_d), 32'(e.d));
    chk({tag, "/illg"}, 32'(obs_i), 32'(e.i));
    for (int k = 0; k < hold; k++) begin
      req = 1'b1; aluOp = 3'b000; a_drv = 32'h1 + 32'(k); b_drv = 32'h3;
      @(posedge clk); #1;
      chk({tag, "/hold_valid"}, 32'(obs_valid), 32'd1);
      chk({tag, "/hold_in_ready"}, 32'(obs_ready), 32'd0);
      chk({tag, "/hold_result"}, obs_res, e.res);
      chk({tag, "/hold_ovf"}, 32'(obs_o), 32'(e.o));
      chk({tag, "/hold_zero"}, 32'(obs_z), 32'(e.z));
    end
    req = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "/release_valid"}, 32'(obs_valid), 32'd0);
    chk({tag, "/release_in_ready"}, 32'(obs_ready), 32'd1);
  endtask

  initial begin
    int seen;
    req = 1'b0; sel = 0; aluOp = '0; func = '0; a_drv = '0; b_drv = '0; out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      chk("reset/in_ready", 32'(obs_ready), 32'd1);
      chk("reset/out_valid", 32'(obs_valid), 32'd0);
      chk("reset/busy", 32'(obs_busy), 32'd0);
      chk("reset/result", obs_res, 32'd0);
      chk("reset/aluCtr", 32'(obs_ctr), 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    //  sel op      func     a             b             result        ctr z  o  d  i  lat hold
    op(2, 3'b000, 4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 3'd0, 0, 1, 0, 0, 1, 0, "add32_ovf");
    op(2, 3'b001, 4'b0000, 32'hFFFFFFFD, 32'h00000002, 32'h00000001, 3'd5, 0, 0, 0, 0, 1, 0, "slt32");
    op(2, 3'b100, 4'b0011, 32'h0000000F, 32'h0000000F, 32'h00000000, 3'd1, 1, 0, 0, 0, 1, 0, "rsub32");
    op(2, 3'b010, 4'b0000, 32'h0000F0F0, 32'h00000FF0, 32'h0000FF00, 3'd4, 0, 0, 0, 0, 1, 0, "xor32");
    op(2, 3'b011, 4'b0000, 32'h00000005, 32'h00000005, 32'h00000000, 3'd4, 1, 0, 0, 0, 1, 0, "op011");
    op(2, 3'b101, 4'b0100, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 3'd2, 0, 0, 0, 0, 1, 0, "rand32");
    op(2, 3'b100, 4'b0110, 32'h00F000F0, 32'h0F0F0000, 32'h0FFF00F0, 3'd3, 0, 0, 0, 0, 1, 0, "ror32");
    op(0, 3'b100, 4'b1100, 32'd13,       32'd11,       32'h0000008F, 3'd6, 0, 0, 0, 0, 9, 0, "mul8");
    op(0, 3'b100, 4'b1110, 32'd200,      32'd7,        32'd28,       3'd7, 0, 0, 0, 0, 9, 0, "divu8");
    op(0, 3'b100, 4'b1100, 32'hFF,       32'hFF,       32'h00000001, 3'd6, 0, 0, 0, 0, 9, 0, "mul8_wrap");
    op(0, 3'b100, 4'b1110, 32'd7,        32'd200,      32'd0,        3'd7, 1, 0, 0, 0, 9, 0, "divu8_small");
    op(0, 3'b100, 4'b1110, 32'd200,      32'd0,        32'h000000FF, 3'd7, 0, 0, 1, 0, 1, 0, "divu8_dz");
    op(1, 3'b100, 4'b1100, 32'd13,       32'd11,       32'd0,        3'd6, 1, 0, 0, 1, 1, 0, "mul8_illg");
    op(0, 3'b000, 4'b0000, 32'h80,       32'h80,       32'h00,       3'd0, 1, 1, 0, 0, 1, 0, "add8_wrap");
    op(0, 3'b001, 4'b0000, 32'h80,       32'h7F,       32'h01,       3'd5, 0, 0, 0, 0, 1, 0, "slt8_min");
    op(0, 3'b100, 4'b0010, 32'h80,       32'h01,       32'h7F,       3'd1, 0, 1, 0, 0, 1, 5, "sub8_bp");

    // reset in the middle of a MUL: the operation must vanish without a result pulse
    sel = 0; aluOp = 3'b100; func = 4'b1100; a_drv = 32'd13; b_drv = 32'd11; req = 1'b1;
    @(posedge clk); #1; req = 1'b0;
    chk("rst_mid/busy_before", 32'(obs_busy), 32'd1);
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid/busy", 32'(obs_busy), 32'd0);
    chk("rst_mid/out_valid", 32'(obs_valid), 32'd0);
    chk("rst_mid/in_ready", 32'(obs_ready), 32'd1);
    chk("rst_mid/result", obs_res, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (obs_valid === 1'b1) seen++;
    end
    chk("rst_mid/no_pulse", seen, 0);

    op(0, 3'b100, 4'b1100, 32'd13,       32'd11,       32'h0000008F, 3'd6, 0, 0, 0, 0, 9, 0, "mul8_after_rst");
    chk("scoreboard/empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
